// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug controller: command
// encodings, FSM state encodings and default geometry.
package rf_dbg_pkg;

   localparam int DEF_NREGS = 32;
   localparam int DEF_AW    = 5;
   localparam int DEF_DW    = 32;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_DUMP  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR   = 3'd2,
      ST_DUMP = 3'd3,
      ST_CLR  = 3'd4
   } state_e;

endpackage

// File: rtl/rf_dbg_rsp_reg.sv
// Single-entry response register: loads a beat, holds it until the host
// takes it, and reports whether a new beat may be loaded this cycle.
module rf_dbg_rsp_reg
   import rf_dbg_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          can_load
);

   // Handshake: a beat transfers on a rising edge where out_valid & out_ready;
   // once out_valid rises, the beat fields stay frozen until that transfer.
   assign can_load = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_addr  <= in_addr;
         out_data  <= in_data;
         out_last  <= in_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rf_dbg_ctrl.sv
// Debug/initialisation master for the register file: single read/write,
// full dump and full clear. Define RF_DBG_CHECKSUM_EN to append an XOR beat to DUMP.
module rf_dbg_ctrl
   import rf_dbg_pkg::*;
#(
   parameter int            NREGS     = DEF_NREGS,
   parameter int            AW        = DEF_AW,
   parameter int            DW        = DEF_DW,
   parameter logic [DW-1:0] CLEAR_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_data,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [AW-1:0] rsp_addr,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_last,
   output logic          busy,
   output logic [AW-1:0] rf_a1,
   input  logic [DW-1:0] rf_rd1,
   output logic [AW-1:0] rf_a3,
   output logic [DW-1:0] rf_wd3,
   output logic          rf_we
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   state_e        state, state_d;
   logic [AW-1:0] idx, idx_d;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;
   logic          accept;
   logic          rsp_load, rsp_can_load, rsp_last_d;
   logic [AW-1:0] rsp_addr_d;
   logic [DW-1:0] rsp_data_d;

`ifdef RF_DBG_CHECKSUM_EN
   logic [DW-1:0] acc, acc_d;
   logic          ck_phase, ck_phase_d;
`endif

   assign cmd_ready = (state == ST_IDLE) && !rsp_valid;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         idx    <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         state <= state_d;
         idx   <= idx_d;
         if (accept) begin
            addr_q <= cmd_addr;
            data_q <= cmd_data;
         end
      end
   end

`ifdef RF_DBG_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc      <= '0;
         ck_phase <= 1'b0;
      end else begin
         acc      <= acc_d;
         ck_phase <= ck_phase_d;
      end
   end
`endif

   always_comb begin
      state_d    = state;
      idx_d      = idx;
      rsp_load   = 1'b0;
      rsp_addr_d = idx;
      rsp_data_d = rf_rd1;
      rsp_last_d = 1'b0;
      rf_a1      = '0;
      rf_a3      = '0;
      rf_wd3     = '0;
      rf_we      = 1'b0;
`ifdef RF_DBG_CHECKSUM_EN
      acc_d      = acc;
      ck_phase_d = ck_phase;
`endif
      case (state)
         ST_IDLE: begin
            if (accept) begin
               idx_d = '0;
`ifdef RF_DBG_CHECKSUM_EN
               acc_d      = '0;
               ck_phase_d = 1'b0;
`endif
               case (op_e'(cmd_op))
                  OP_READ:  state_d = ST_RD;
                  OP_WRITE: state_d = ST_WR;
                  OP_DUMP:  state_d = ST_DUMP;
                  default:  state_d = ST_CLR;
               endcase
            end
         end
         // The response register is known empty here: accept required !rsp_valid.
         ST_RD: begin
            rf_a1      = addr_q;
            rsp_load   = 1'b1;
            rsp_addr_d = addr_q;
            rsp_last_d = 1'b1;
            state_d    = ST_IDLE;
         end
         ST_WR: begin
            rf_we   = 1'b1;
            rf_a3   = addr_q;
            rf_wd3  = data_q;
            state_d = ST_IDLE;
         end
         ST_DUMP: begin
            rf_a1 = idx;
            if (rsp_can_load) begin
               rsp_load = 1'b1;
`ifdef RF_DBG_CHECKSUM_EN
               if (ck_phase) begin
                  rsp_addr_d = '0;
                  rsp_data_d = acc;
                  rsp_last_d = 1'b1;
                  ck_phase_d = 1'b0;
                  state_d    = ST_IDLE;
               end else begin
                  acc_d = acc ^ rf_rd1;
                  if (idx == LAST_IDX) begin
                     idx_d      = '0;
                     ck_phase_d = 1'b1;
                  end else begin
                     idx_d = idx + AW'(1);
                  end
               end
`else
               rsp_last_d = (idx == LAST_IDX);
               if (idx == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx + AW'(1);
               end
`endif
            end
         end
         ST_CLR: begin
            rf_we  = 1'b1;
            rf_a3  = idx;
            rf_wd3 = CLEAR_VAL;
            if (idx == LAST_IDX) begin
               idx_d   = '0;
               state_d = ST_IDLE;
            end else begin
               idx_d = idx + AW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   rf_dbg_rsp_reg #(.AW(AW), .DW(DW)) u_rsp (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (rsp_load),
      .in_addr   (rsp_addr_d),
      .in_data   (rsp_data_d),
      .in_last   (rsp_last_d),
      .out_ready (rsp_ready),
      .out_valid (rsp_valid),
      .out_addr  (rsp_addr),
      .out_data  (rsp_data),
      .out_last  (rsp_last),
      .can_load  (rsp_can_load)
   );

endmodule

// File: tb/tb_rf_dbg_ctrl.sv
// Self-checking bench for rf_dbg_ctrl with a behavioural register file and
// a command-level model of the expected response beats.
module tb_rf_dbg_ctrl;
   import rf_dbg_pkg::*;

   localparam int            NREGS     = 32;
   localparam int            AW        = 5;
   localparam int            DW        = 32;
   localparam int            BW        = 1 + AW + DW;
   localparam logic [DW-1:0] CLEAR_VAL = '0;
`ifdef RF_DBG_CHECKSUM_EN
   localparam int NBEATS = NREGS + 1;
`else
   localparam int NBEATS = NREGS;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic          rsp_valid, rsp_ready, rsp_last, busy;
   logic [AW-1:0] rsp_addr, rf_a1, rf_a3;
   logic [DW-1:0] rsp_data, rf_rd1, rf_wd3;
   logic          rf_we;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int ready_mode = 0;
   int got_rd = 0;

   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] got_q[$];
   int            got_cyc_q[$];
   logic [DW-1:0] model_rf [NREGS];
   logic [DW-1:0] rf_mem [NREGS];

   rf_dbg_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
      .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
      .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we(rf_we)
   );

   // clock / reset-independent infrastructure
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // register file stand-in: x0 reads zero and ignores writes
   assign rf_rd1 = (rf_a1 == '0) ? '0 : rf_mem[rf_a1];
   always @(posedge clk) if (rf_we && rf_a3 != '0) rf_mem[rf_a3] <= rf_wd3;

   // beat monitor: a beat seen valid&ready here transfers on the next rising edge
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         got_q.push_back({rsp_last, rsp_addr, rsp_data});
         got_cyc_q.push_back(cyc);
      end
   end

   // host ready pattern: 0 = always ready, 1 = toggling, 2 = random
   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            1:       rsp_ready = ~rsp_ready;
            2:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b1;
         endcase
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      return (a == '0) ? '0 : model_rf[a];
   endfunction

   task automatic exp_dump();
`ifdef RF_DBG_CHECKSUM_EN
      logic [DW-1:0] x = '0;
      for (int i = 0; i < NREGS; i++) begin
         x ^= model_read(AW'(i));
         exp_q.push_back({1'b0, AW'(i), model_read(AW'(i))});
      end
      exp_q.push_back({1'b1, AW'(0), x});
`else
      for (int i = 0; i < NREGS; i++)
         exp_q.push_back({(i == NREGS - 1), AW'(i), model_read(AW'(i))});
`endif
   endtask

   // ---------------- driver tasks ----------------
   // all driver tasks start and end 1 time unit after a rising edge
   task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      while (!cmd_ready && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) begin
         total++; bad++;
         $display("FAIL cmd_accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_data  = $urandom;
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
      case (op)
         OP_READ:  exp_q.push_back({1'b1, a, model_read(a)});
         OP_WRITE: model_rf[a] = d;
         OP_DUMP:  exp_dump();
         default:  for (int i = 0; i < NREGS; i++) model_rf[i] = CLEAR_VAL;
      endcase
      send_cmd(op, a, d);
   endtask

   task automatic wait_beats(input int n, input int budget);
      int k = 0;
      while (got_q.size() < got_rd + n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic preload();
      for (int i = 1; i < NREGS; i++) do_cmd(OP_WRITE, AW'(i), 32'(i) * 32'h0101_0101);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_last, busy, rf_we} !== 4'b0) begin
         bad++;
         $display("FAIL reset_flags: valid/last/busy/we=%b required 0000", {rsp_valid, rsp_last, busy, rf_we});
      end
      total++;
      if ({rsp_addr, rsp_data} !== '0) begin
         bad++;
         $display("FAIL reset_rsp: addr=%0d data=%h required 0", rsp_addr, rsp_data);
      end
      total++;
      if ({rf_a1, rf_a3, rf_wd3} !== '0) begin
         bad++;
         $display("FAIL reset_rf: a1=%0d a3=%0d wd3=%h required 0", rf_a1, rf_a3, rf_wd3);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      int we_cnt = 0;
      logic [BW-1:0] e, g;
      ready_mode = 0;
      do_cmd(OP_WRITE, AW'(5), 32'hDEAD_BEEF);
      repeat (4) begin
         @(negedge clk);
         if (rf_we) begin
            we_cnt++;
            total++;
            if (rf_a3 !== AW'(5) || rf_wd3 !== 32'hDEAD_BEEF) begin
               bad++;
               $display("FAIL write_port: a3=%0d wd3=%h required 5 deadbeef", rf_a3, rf_wd3);
            end
         end
      end
      @(posedge clk); #1;
      total++;
      if (we_cnt !== 1) begin
         bad++;
         $display("FAIL write_we_cycles: got %0d required 1", we_cnt);
      end
      do_cmd(OP_READ, AW'(5), '0);
      wait_beats(exp_q.size(), 50);
      total++;
      if (got_q.size() - got_rd !== exp_q.size()) begin
         bad++;
         $display("FAIL read_count: got %0d beats required %0d", got_q.size() - got_rd, exp_q.size());
      end
      while (exp_q.size() > 0 && got_rd < got_q.size()) begin
         e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL read_beat: got last=%b addr=%0d data=%h required last=%b addr=%0d data=%h",
                     g[BW-1], g[DW+:AW], g[DW-1:0], e[BW-1], e[DW+:AW], e[DW-1:0]);
         end
      end
      exp_q.delete(); got_rd = got_q.size();
   endtask

   task automatic test_dump();
      logic [BW-1:0] e, g;
      int first;
      ready_mode = 0;
      first = got_rd;
      do_cmd(OP_DUMP, '0, '0);
      wait_beats(exp_q.size(), 200);
      if (got_q.size() >= first + NBEATS) begin
         total++;
         if (got_cyc_q[first + NBEATS - 1] - got_cyc_q[first] !== NBEATS - 1) begin
            bad++;
            $display("FAIL dump_throughput: span %0d cycles required %0d",
                     got_cyc_q[first + NBEATS - 1] - got_cyc_q[first], NBEATS - 1);
         end
      end
      total++;
      if (got_q.size() - got_rd !== exp_q.size()) begin
         bad++;
         $display("FAIL dump_count: got %0d beats required %0d", got_q.size() - got_rd, exp_q.size());
      end
      while (exp_q.size() > 0 && got_rd < got_q.size()) begin
         e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL dump_beat: got last=%b addr=%0d data=%h required last=%b addr=%0d data=%h",
                     g[BW-1], g[DW+:AW], g[DW-1:0], e[BW-1], e[DW+:AW], e[DW-1:0]);
         end
      end
      exp_q.delete(); got_rd = got_q.size();
   endtask

   task automatic test_dump_stall();
      logic [BW-1:0] e, g, held;
      logic stalled = 1'b0;
      int taken = 0;
      int n = 0;
      ready_mode = 1;
      held = '0;
      do_cmd(OP_DUMP, '0, '0);
      while (taken < NBEATS && n < 400) begin
         @(negedge clk);
         n++;
         total++;
         if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_cmd_ready: got %b required 0 with %0d beats taken", cmd_ready, taken);
         end
         if (stalled) begin
            total++;
            if ({rsp_valid, rsp_last, rsp_addr, rsp_data} !== {1'b1, held}) begin
               bad++;
               $display("FAIL stall_hold: got valid=%b beat=%h required valid=1 beat=%h",
                        rsp_valid, {rsp_last, rsp_addr, rsp_data}, held);
            end
         end
         stalled = rsp_valid && !rsp_ready;
         held    = {rsp_last, rsp_addr, rsp_data};
         if (rsp_valid && rsp_ready) taken++;
      end
      total++;
      if (taken !== NBEATS) begin
         bad++;
         $display("FAIL stall_timeout: took %0d beats required %0d", taken, NBEATS);
      end
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL stall_cmd_ready_end: got %b required 1", cmd_ready);
      end
      @(posedge clk); #1;
      ready_mode = 0;
      total++;
      if (got_q.size() - got_rd !== exp_q.size()) begin
         bad++;
         $display("FAIL stall_count: got %0d beats required %0d", got_q.size() - got_rd, exp_q.size());
      end
      while (exp_q.size() > 0 && got_rd < got_q.size()) begin
         e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL stall_beat: got last=%b addr=%0d data=%h required last=%b addr=%0d data=%h",
                     g[BW-1], g[DW+:AW], g[DW-1:0], e[BW-1], e[DW+:AW], e[DW-1:0]);
         end
      end
      exp_q.delete(); got_rd = got_q.size();
   endtask

   task automatic test_clear();
      logic [BW-1:0] e, g;
      int we_cnt = 0;
      ready_mode = 0;
      do_cmd(OP_CLEAR, AW'($urandom), $urandom);
      repeat (NREGS + 8) begin
         @(negedge clk);
         if (rf_we) begin
            total++;
            if (busy !== 1'b1 || rf_a3 !== AW'(we_cnt) || rf_wd3 !== CLEAR_VAL) begin
               bad++;
               $display("FAIL clear_write: busy=%b a3=%0d wd3=%h required busy=1 a3=%0d wd3=%h",
                        busy, rf_a3, rf_wd3, we_cnt, CLEAR_VAL);
            end
            we_cnt++;
         end
      end
      total++;
      if (we_cnt !== NREGS || busy !== 1'b0) begin
         bad++;
         $display("FAIL clear_cycles: we cycles=%0d busy=%b required %0d and 0", we_cnt, busy, NREGS);
      end
      @(posedge clk); #1;
      do_cmd(OP_DUMP, '0, '0);
      wait_beats(exp_q.size(), 200);
      total++;
      if (got_q.size() - got_rd !== exp_q.size()) begin
         bad++;
         $display("FAIL clear_dump_count: got %0d beats required %0d", got_q.size() - got_rd, exp_q.size());
      end
      while (exp_q.size() > 0 && got_rd < got_q.size()) begin
         e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL clear_dump_beat: got last=%b addr=%0d data=%h required last=%b addr=%0d data=%h",
                     g[BW-1], g[DW+:AW], g[DW-1:0], e[BW-1], e[DW+:AW], e[DW-1:0]);
         end
      end
      exp_q.delete(); got_rd = got_q.size();
   endtask

   task automatic test_reset_mid();
      logic [BW-1:0] e, g;
      int taken = 0;
      int n = 0;
      ready_mode = 0;
      preload();
      for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, AW'(i), model_read(AW'(i))});
      send_cmd(OP_DUMP, '0, '0);
      while (taken < 10 && n < 200) begin
         @(negedge clk);
         n++;
         if (rsp_valid && rsp_ready) taken++;
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({rsp_valid, rf_we, busy} !== 3'b000) begin
         bad++;
         $display("FAIL midreset_outputs: valid/we/busy=%b required 000", {rsp_valid, rf_we, busy});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL midreset_cmd_ready: got %b required 1", cmd_ready);
      end
      @(posedge clk); #1;
      do_cmd(OP_READ, AW'(3), '0);
      wait_beats(1, 50);
      total++;
      if (got_q.size() - got_rd !== exp_q.size()) begin
         bad++;
         $display("FAIL midreset_count: got %0d beats required %0d", got_q.size() - got_rd, exp_q.size());
      end
      while (exp_q.size() > 0 && got_rd < got_q.size()) begin
         e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL midreset_beat: got last=%b addr=%0d data=%h required last=%b addr=%0d data=%h",
                     g[BW-1], g[DW+:AW], g[DW-1:0], e[BW-1], e[DW+:AW], e[DW-1:0]);
         end
      end
      exp_q.delete(); got_rd = got_q.size();
   endtask

   task automatic test_back_to_back();
      logic [BW-1:0] e, g;
      int r;
      ready_mode = 2;
      for (int k = 0; k < 60; k++) begin
         r = $urandom_range(0, 19);
         if (r < 10)       do_cmd(OP_READ, AW'($urandom), $urandom);
         else if (r < 17)  do_cmd(OP_WRITE, AW'($urandom), $urandom);
         else if (r < 19)  do_cmd(OP_DUMP, AW'($urandom), $urandom);
         else              do_cmd(OP_CLEAR, AW'($urandom), $urandom);
      end
      wait_beats(exp_q.size(), 5000);
      ready_mode = 0;
      total++;
      if (got_q.size() - got_rd !== exp_q.size()) begin
         bad++;
         $display("FAIL random_count: got %0d beats required %0d", got_q.size() - got_rd, exp_q.size());
      end
      while (exp_q.size() > 0 && got_rd < got_q.size()) begin
         e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL random_beat: got last=%b addr=%0d data=%h required last=%b addr=%0d data=%h",
                     g[BW-1], g[DW+:AW], g[DW-1:0], e[BW-1], e[DW+:AW], e[DW-1:0]);
         end
      end
      exp_q.delete(); got_rd = got_q.size();
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_addr  = '0;
      cmd_data  = '0;
      test_reset();
      test_write_read();
      preload();
      test_dump();
      test_dump_stall();
      test_clear();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
